// File: rtl/led_blink_scheduler.sv
// led_blink_scheduler: round-robin LED rate arbiter with dwell and gap; LED_SCHED_PREEMPT_EN makes requester 0 urgent
module led_blink_scheduler #(
  parameter int DWELL_CYCLES = 33000000,
  parameter int GAP_CYCLES   = 6600000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [7:0] rate,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       en,
  output logic       busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  logic [1:0]    state_q, state_d;
  logic [3:0]    grant_q, grant_d;
  logic [1:0]    sel_q, sel_d;
  logic          en_q, en_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [1:0]    owner, win;
  logic          dwell_done, release_now, preempt;
  // owner index, round-robin winner and release/preempt decisions
  always_comb begin
    owner       = {grant_q[3] | grant_q[2], grant_q[3] | grant_q[1]};
    win         = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (req[rr_ptr_q + 2'(k)]) win = rr_ptr_q + 2'(k);
    dwell_done  = (dwell_cnt_q == DWELL_LAST);
    release_now = dwell_done && (!req[owner] || (|(req & ~grant_q)));
`ifdef LED_SCHED_PREEMPT_EN
    preempt     = (owner != 2'd0) && req[0];
`else
    preempt     = 1'b0;
`endif
  end
  // next-state logic for the IDLE / GRANT / GAP sequencer
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    en_d        = en_q;
    rr_ptr_d    = rr_ptr_q;
    dwell_cnt_d = dwell_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    case (state_q)
      IDLE: if (|req) begin
        grant_d     = 4'b0001 << win;
        sel_d       = rate[{win, 1'b0} +: 2];
        en_d        = 1'b1;
        dwell_cnt_d = '0;
        state_d     = GRANT;
      end
      GRANT: if (preempt) begin
        grant_d     = 4'b0001;
        sel_d       = rate[1:0];
        en_d        = 1'b1;
        dwell_cnt_d = '0;
        rr_ptr_d    = owner + 2'd1;
      end else begin
        sel_d       = req[owner] ? rate[{owner, 1'b0} +: 2] : sel_q;
        dwell_cnt_d = dwell_done ? dwell_cnt_q : dwell_cnt_q + DW'(1);
        if (release_now) begin
          grant_d   = 4'b0000;
          en_d      = 1'b0;
          rr_ptr_d  = owner + 2'd1;
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        state_d   = (gap_cnt_q == GAP_LAST) ? IDLE : GAP;
        gap_cnt_d = (gap_cnt_q == GAP_LAST) ? gap_cnt_q : gap_cnt_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      sel_q       <= '0;
      en_q        <= 1'b0;
      rr_ptr_q    <= '0;
      dwell_cnt_q <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      en_q        <= en_d;
      rr_ptr_q    <= rr_ptr_d;
      dwell_cnt_q <= dwell_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end
  assign grant = grant_q;
  assign sel   = sel_q;
  assign en    = en_q;
  assign busy  = (state_q != IDLE);
endmodule

// File: tb/tb_led_blink_scheduler.sv
// tb_led_blink_scheduler: scoreboard bench for led_blink_scheduler with a behavioural owner/countdown model
module tb_led_blink_scheduler;
  localparam int D = 8;
  localparam int G = 2;
  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
    logic       e;
    logic       b;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [7:0] rate = 8'h00;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       en, busy;
  exp_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         m_owner = -1;
  int         m_held = 0;
  int         m_wait = 0;
  int         m_ptr = 0;
  logic [1:0] m_sel = 2'd0;
  led_blink_scheduler #(.DWELL_CYCLES(D), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .req(req), .rate(rate),
    .grant(grant), .sel(sel), .en(en), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [1:0] rate_of(input logic [7:0] r, input int i);
    return 2'((r >> (2 * i)) & 8'h3);
  endfunction
  task automatic model_edge(input logic r_rst, input logic [3:0] r_req, input logic [7:0] r_rate);
    bit others;
    if (r_rst) begin
      m_owner = -1; m_held = 0; m_wait = 0; m_ptr = 0; m_sel = 2'd0;
      return;
    end
    if (m_owner >= 0) begin
`ifdef LED_SCHED_PREEMPT_EN
      if (m_owner != 0 && r_req[0]) begin
        m_ptr = (m_owner + 1) % 4; m_owner = 0; m_held = 0; m_sel = rate_of(r_rate, 0);
        return;
      end
`endif
      if (r_req[m_owner]) m_sel = rate_of(r_rate, m_owner);
      others = (r_req & ~(4'b0001 << m_owner)) != 4'b0000;
      if (m_held >= D - 1 && (!r_req[m_owner] || others)) begin
        m_ptr = (m_owner + 1) % 4; m_owner = -1; m_wait = G;
      end else m_held++;
    end else if (m_wait > 0) m_wait--;
    else if (r_req != 4'b0000) begin
      for (int k = 0; k < 4; k++)
        if (m_owner < 0 && r_req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
      m_held = 0;
      m_sel = rate_of(r_rate, m_owner);
    end
  endtask
  task automatic cyc(input logic r_rst, input logic [3:0] r_req, input logic [7:0] r_rate);
    exp_t e;
    @(negedge clk);
    rst = r_rst; req = r_req; rate = r_rate;
    model_edge(r_rst, r_req, r_rate);
    e.g = (m_owner >= 0) ? 4'(4'b0001 << m_owner) : 4'b0000;
    e.s = m_sel;
    e.e = (m_owner >= 0);
    e.b = (m_owner >= 0) || (m_wait > 0);
    exp_q.push_back(e);
  endtask
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, want);
    end
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant", grant, e.g);
        chk("sel", {2'b00, sel}, {2'b00, e.s});
        chk("en", {3'b000, en}, {3'b000, e.e});
        chk("busy", {3'b000, busy}, {3'b000, e.b});
      end
    end
  end
  initial begin : stim
    logic [3:0] r;
    logic [7:0] rt;
    logic       rs;
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'b1111, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b1111, 8'h00);
    cyc(1'b1, 4'b0000, 8'h00);
    for (int i = 0; i < 30; i++) cyc(1'b0, 4'b0100, 8'h30);
    cyc(1'b1, 4'b0000, 8'h00);
    for (int i = 0; i < 40; i++) cyc(1'b0, 4'b1010, 8'b10_00_01_00);
    cyc(1'b1, 4'b0000, 8'h00);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'b0010, 8'h0C);
    for (int i = 0; i < 15; i++) cyc(1'b0, 4'b0000, 8'h0C);
    cyc(1'b1, 4'b0000, 8'h00);
    for (int i = 0; i < 5; i++) cyc(1'b0, 4'b0001, 8'h00);
    cyc(1'b0, 4'b0001, 8'h02);
    cyc(1'b1, 4'b0001, 8'h02);
    cyc(1'b0, 4'b0000, 8'h02);
    cyc(1'b1, 4'b0000, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0100, 8'h21);
    for (int i = 0; i < 20; i++) cyc(1'b0, 4'b0101, 8'h21);
    cyc(1'b1, 4'b0000, 8'h00);
    r = 4'b0000; rt = 8'h00;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(7) == 0) r = 4'($urandom);
      if ($urandom_range(3) == 0) rt = 8'($urandom);
      rs = ($urandom_range(199) == 0);
      cyc(rs, r, rt);
    end
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
